// File: rtl/sio_pkg.sv
// Shared types and default sizing for the SIO transmit scheduler.
package sio_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY} sio_state_t;

    localparam int SIO_GAP_BITS_DEF = 20;
    localparam int SIO_DATA_W_DEF   = 10;
    localparam int SIO_GAP_CNT_W    = $clog2(SIO_GAP_BITS_DEF + 1);
    localparam int SIO_BIT_CNT_W    = $clog2(SIO_DATA_W_DEF);

endpackage

// File: rtl/sio_rr_arbiter.sv
// Combinational round-robin arbiter: first valid request at or after ptr wins.
module sio_rr_arbiter
#(
    parameter int NREQ = 4,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
)
(
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    input  logic            en,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   idx
);

    logic [2*NREQ-1:0] dbl;
    logic [NREQ-1:0]   rot;
    logic              found;

    always_comb begin
        dbl   = {req, req} >> ptr;
        rot   = dbl[NREQ-1:0];
        idx   = '0;
        found = 1'b0;
        // rot[k] is requester ptr+k (mod NREQ); the lowest set bit wins
        for (int k = 0; k < NREQ; k++) begin
            if (en && !found && rot[k]) begin
                found = 1'b1;
                if (int'(ptr) + k >= NREQ)
                    idx = IW'(int'(ptr) + k - NREQ);
                else
                    idx = IW'(int'(ptr) + k);
            end
        end
        grant = found ? (NREQ'(1) << idx) : '0;
    end

endmodule

// File: rtl/sio_tx_scheduler.sv
// Round-robin serial frame transmitter on one SIO line.
// Define SIO_PARITY_EN to append an odd-parity bit after the data bits.
module sio_tx_scheduler
    import sio_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int DATA_W   = SIO_DATA_W_DEF,
    parameter int GAP_BITS = SIO_GAP_BITS_DEF,
    parameter int CLKDIV   = 16,
    parameter int IW       = (NREQ > 1) ? $clog2(NREQ) : 1
)
(
    input  logic                     MCLK,
    input  logic                     RESET,
    input  logic [NREQ-1:0]          ReqValid,
    input  logic [NREQ*DATA_W-1:0]   ReqData,
    output logic [NREQ-1:0]          ReqReady,
    output logic                     SioDat,
    output logic                     Busy,
    output logic [IW-1:0]            GrantId,
    output logic                     FrameDone
);

    localparam int DVW = $clog2(CLKDIV);
    localparam int GCW = $clog2(GAP_BITS + 1);
    localparam int BCW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [1:0] S_IDLE   = ST_IDLE;
    localparam logic [1:0] S_START  = ST_START;
    localparam logic [1:0] S_DATA   = ST_DATA;
    localparam logic [1:0] S_PARITY = ST_PARITY;

    logic [DVW-1:0]    div;
    logic              tick;
    logic [1:0]        state;
    logic [GCW-1:0]    gap;
    logic [BCW-1:0]    bitcnt;
    logic [DATA_W-1:0] shreg;
    logic [IW-1:0]     rrptr;
    logic              fire;
    logic [NREQ-1:0]   grant;
    logic [IW-1:0]     gidx;
    logic [DATA_W-1:0] words [NREQ];
`ifdef SIO_PARITY_EN
    logic              par;
`endif

    for (genvar i = 0; i < NREQ; i++) begin : g_words
        assign words[i] = ReqData[i*DATA_W +: DATA_W];
    end

    assign tick = (div == DVW'(CLKDIV - 1));
    assign fire = !RESET && tick && (state == S_IDLE) && (gap == GCW'(GAP_BITS)) && (|ReqValid);
    assign Busy = (state != S_IDLE);

    sio_rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
        .req   (ReqValid),
        .ptr   (rrptr),
        .en    (fire),
        .grant (grant),
        .idx   (gidx)
    );

    // The accept pulse is the arbiter grant itself, live only on the launching tick
    assign ReqReady = grant;

    always_ff @(posedge MCLK) begin
        if (RESET) begin
            div       <= '0;
            state     <= S_IDLE;
            gap       <= '0;
            bitcnt    <= '0;
            shreg     <= '0;
            rrptr     <= '0;
            SioDat    <= 1'b0;
            GrantId   <= '0;
            FrameDone <= 1'b0;
        end else begin
            div       <= tick ? '0 : div + 1'b1;
            FrameDone <= 1'b0;
            if (tick) begin
                case (state)
                    S_IDLE: begin
                        if (fire) begin
                            state   <= S_START;
                            SioDat  <= 1'b1;
                            shreg   <= words[gidx];
                            GrantId <= gidx;
                            rrptr   <= (gidx == IW'(NREQ - 1)) ? '0 : gidx + 1'b1;
`ifdef SIO_PARITY_EN
                            par     <= ~^words[gidx];
`endif
                        end else if (gap != GCW'(GAP_BITS)) begin
                            gap <= gap + 1'b1;
                        end
                    end
                    S_START: begin
                        state  <= S_DATA;
                        SioDat <= shreg[DATA_W-1];
                        shreg  <= shreg << 1;
                        bitcnt <= '0;
                    end
                    S_DATA: begin
                        if (bitcnt == BCW'(DATA_W - 1)) begin
`ifdef SIO_PARITY_EN
                            state  <= S_PARITY;
                            SioDat <= par;
`else
                            state     <= S_IDLE;
                            SioDat    <= 1'b0;
                            FrameDone <= 1'b1;
                            gap       <= '0;
`endif
                        end else begin
                            SioDat <= shreg[DATA_W-1];
                            shreg  <= shreg << 1;
                            bitcnt <= bitcnt + 1'b1;
                        end
                    end
                    default: begin
                        // parity bit has just ended (or an unused encoding): close the frame
                        state     <= S_IDLE;
                        SioDat    <= 1'b0;
                        FrameDone <= (state == S_PARITY);
                        gap       <= '0;
                    end
                endcase
            end
        end
    end

endmodule
